reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16, giving the number of cycles all domains are held in reset before the PLL lock check (minimum 1).
REQ-002 SHALL have parameter MEM_DELAY, default 8, giving the number of cycles from peripheral release to memory release (minimum 1).
REQ-003 SHALL have parameter CPU_DELAY, default 8, giving the number of cycles from memory release to CPU release (minimum 1).
REQ-004 SHALL have parameter WDT_CYCLES, default 1024, giving the watchdog timeout in cycles; it is used only with RST_SEQ_WDT_EN.
REQ-005 SHALL have port clk_sys, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset, already synchronized upstream.
REQ-007 SHALL have port pll_locked, input, 1 bit: level; 1 means the system clock is stable.
REQ-008 SHALL have port soft_rst_req, input, 1 bit: one-cycle pulse from the CPU requesting a full re-sequence.
REQ-009 SHALL have port wdt_kick, input, 1 bit: pulse that restarts the watchdog; ignored without RST_SEQ_WDT_EN.
REQ-010 SHALL have port rst_periph, output, 1 bit: active-high reset for the peripheral domain, registered.
REQ-011 SHALL have port rst_mem, output, 1 bit: active-high reset for the memory/bus domain, registered.
REQ-012 SHALL have port rst_cpu, output, 1 bit: active-high reset for the CPU pipeline, registered.
REQ-013 SHALL have port seq_done, output, 1 bit: 1 only in state S_RUN, registered.
REQ-014 SHALL have port rst_cause, output, 2 bits: cause of the last sequence (0 = power-on/rst, 1 = lock loss, 2 = soft, 3 = watchdog).

Function
REQ-015 SHALL implement the states S_HOLD, S_WAIT_LOCK, S_MEM, S_CPU and S_RUN, with one shared down/up counter cleared on every state entry.
REQ-016 S_HOLD SHALL last exactly HOLD_CYCLES edges, with all three resets at 1 and seq_done at 0, and then go to S_WAIT_LOCK.
REQ-017 S_WAIT_LOCK SHALL, on the first edge sampling pll_locked=1, clear rst_periph and go to S_MEM; it waits indefinitely otherwise.
REQ-018 S_MEM SHALL, after exactly MEM_DELAY edges, clear rst_mem and go to S_CPU.
REQ-019 S_CPU SHALL, after exactly CPU_DELAY edges, clear rst_cpu, set seq_done and go to S_RUN.
REQ-020 Release order SHALL always be periph, then mem, then cpu; assertion SHALL be simultaneous for all three on the edge that enters S_HOLD.
REQ-021 pll_locked=0 sampled in S_MEM, S_CPU or S_RUN SHALL cause entry to S_HOLD with rst_cause=1.
REQ-022 soft_rst_req sampled in S_RUN SHALL cause entry to S_HOLD with rst_cause=2; outside S_RUN it SHALL be ignored.
REQ-023 Simultaneous events SHALL follow the priority rst > lock loss > soft_rst_req > watchdog, and only the winner is recorded in rst_cause.
REQ-024 rst_cause SHALL change only on entry to S_HOLD and SHALL otherwise hold its value.
REQ-025 Counter width SHALL be sized to the largest of HOLD_CYCLES, MEM_DELAY, CPU_DELAY and WDT_CYCLES; the counter SHALL never wrap.

Reset
REQ-026 rst=1 at any edge, in any state, SHALL force S_HOLD, counter to 0, rst_periph/rst_mem/rst_cpu to 1, seq_done to 0 and rst_cause to 0.
REQ-027 The first edge with rst=0 SHALL count as S_HOLD cycle 1.

Configuration
REQ-028 Macro RST_SEQ_WDT_EN defined: in S_RUN, a watchdog counter SHALL count edges without wdt_kick and be cleared by wdt_kick; on reaching WDT_CYCLES it SHALL cause entry to S_HOLD with rst_cause=3.
REQ-029 Macro RST_SEQ_WDT_EN undefined: no watchdog logic SHALL exist, wdt_kick SHALL be unused, and rst_cause SHALL never be 3.

Verification
REQ-030 Power-on: rst=1 for 3 edges, then 0 with pll_locked=1 and default parameters -> rst_periph falls after edge 17, rst_mem after edge 25, rst_cpu and seq_done rise/fall after edge 33, rst_cause=0.
REQ-031 Late lock: pll_locked=0 until edge 40 -> all resets remain 1 through edge 39; rst_periph falls after edge 40, rst_mem after edge 48, rst_cpu after edge 56.
REQ-032 Soft reset: soft_rst_req pulse in S_RUN -> all resets 1 and seq_done 0 on the next edge, rst_cause=2, full sequence repeats; a pulse during S_MEM has no effect.
REQ-033 Lock loss plus soft_rst_req on the same edge in S_RUN -> S_HOLD with rst_cause=1; lock loss during S_CPU -> rst_mem returns to 1 on the next edge.
REQ-034 rst asserted mid-S_MEM -> S_HOLD and rst_cause=0 after that edge; with RST_SEQ_WDT_EN and no kick for 1024 edges in S_RUN -> re-sequence with rst_cause=3, while kicks every 500 edges keep seq_done=1.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release for peripheral, memory and CPU domains.
// Holds all domains in reset, waits for PLL lock, then releases
// periph -> mem -> cpu with programmable gaps. Re-sequences on lock
// loss, soft request or (optionally) watchdog timeout.
//
// Optional feature: define RST_SEQ_WDT_EN to build the run-state watchdog.
//
// Ports:
//   clk_sys      in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   pll_locked   in   PLL lock level
//   soft_rst_req in   one-cycle soft re-sequence request
//   wdt_kick     in   watchdog restart pulse (watchdog builds only)
//   rst_periph   out  peripheral domain reset, registered
//   rst_mem      out  memory/bus domain reset, registered
//   rst_cpu      out  CPU pipeline reset, registered
//   seq_done     out  high only while running, registered
//   rst_cause    out  0 por/rst, 1 lock loss, 2 soft, 3 watchdog
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int MEM_DELAY   = 8,
    parameter int CPU_DELAY   = 8,
    parameter int WDT_CYCLES  = 1024
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_rst_req,
    input  logic       wdt_kick,
    output logic       rst_periph,
    output logic       rst_mem,
    output logic       rst_cpu,
    output logic       seq_done,
    output logic [1:0] rst_cause
);

    localparam int MAX_A = (HOLD_CYCLES > MEM_DELAY) ? HOLD_CYCLES : MEM_DELAY;
    localparam int MAX_B = (CPU_DELAY > WDT_CYCLES) ? CPU_DELAY : WDT_CYCLES;
    localparam int MAX_V = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_V + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] MEM_LAST  = CW'(MEM_DELAY - 1);
    localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_DELAY - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_MEM,
        S_CPU,
        S_RUN
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [1:0]      cause_n;
    logic            lock_loss;
    logic            soft_hit;
    logic            wdt_trip;

    // Lock loss only matters once the peripheral domain has been released.
    assign lock_loss = !pll_locked &&
                       (state == S_MEM || state == S_CPU || state == S_RUN);
    assign soft_hit  = soft_rst_req && (state == S_RUN);

`ifdef RST_SEQ_WDT_EN
    localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYCLES - 1);

    // The shared counter doubles as the watchdog while running; it
    // trips on the WDT_CYCLES-th consecutive edge without a kick.
    assign wdt_trip = (state == S_RUN) && !wdt_kick && (cnt == WDT_LAST);
`else
    logic unused_kick;

    assign unused_kick = wdt_kick;
    assign wdt_trip    = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cause_n = rst_cause;
        if (lock_loss) begin
            state_n = S_HOLD;
            cnt_n   = '0;
            cause_n = 2'd1;
        end else if (soft_hit) begin
            state_n = S_HOLD;
            cnt_n   = '0;
            cause_n = 2'd2;
        end else if (wdt_trip) begin
            state_n = S_HOLD;
            cnt_n   = '0;
            cause_n = 2'd3;
        end else begin
            unique case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_n = S_WAIT_LOCK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                S_WAIT_LOCK: begin
                    if (pll_locked) begin
                        state_n = S_MEM;
                        cnt_n   = '0;
                    end
                end
                S_MEM: begin
                    if (cnt == MEM_LAST) begin
                        state_n = S_CPU;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                S_CPU: begin
                    if (cnt == CPU_LAST) begin
                        state_n = S_RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                S_RUN: begin
`ifdef RST_SEQ_WDT_EN
                    if (wdt_kick) begin
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
`else
                    cnt_n = '0;
`endif
                end
                default: begin
                    state_n = S_HOLD;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so each reset changes
    // on the same edge that makes the corresponding transition.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state      <= S_HOLD;
            cnt        <= '0;
            rst_periph <= 1'b1;
            rst_mem    <= 1'b1;
            rst_cpu    <= 1'b1;
            seq_done   <= 1'b0;
            rst_cause  <= 2'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rst_periph <= (state_n == S_HOLD) || (state_n == S_WAIT_LOCK);
            rst_mem    <= (state_n == S_HOLD) || (state_n == S_WAIT_LOCK) ||
                          (state_n == S_MEM);
            rst_cpu    <= (state_n != S_RUN);
            seq_done   <= (state_n == S_RUN);
            rst_cause  <= cause_n;
        end
    end

endmodule
